// File: rtl/sc_pkg.sv
// sc_pkg: shared encodings and constants for the stochastic-computing blocks.
package sc_pkg;

    typedef enum logic [1:0] {
        SC_IDLE = 2'd0,
        SC_RUN  = 2'd1,
        SC_DONE = 2'd2
    } sc_state_e;

    localparam int          SC_LFSR_W     = 16;
    localparam logic [15:0] SC_LFSR_TAPS  = 16'hB400;
    localparam int          SC_SEL_LFSR   = 0;
    localparam int          SC_SEL_TOGGLE = 1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1; taps are bits 15,13,12,10
    function automatic logic [SC_LFSR_W-1:0] sc_lfsr_next(input logic [SC_LFSR_W-1:0] s);
        return {s[SC_LFSR_W-2:0], ^(s & SC_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_lfsr16.sv
// sc_lfsr16: 16-bit Fibonacci LFSR with synchronous load and step enable.
module sc_lfsr16
    import sc_pkg::*;
#(
    parameter logic [SC_LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [SC_LFSR_W-1:0] seed,
    output logic [SC_LFSR_W-1:0] q
);

    logic [SC_LFSR_W-1:0] q_q;
    logic [SC_LFSR_W-1:0] q_d;

    assign q_d = load ? seed : step ? sc_lfsr_next(q_q) : q_q;
    assign q   = q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

endmodule

// File: rtl/sc_adder_ctrl.sv
// sc_adder_ctrl: sequences one stochastic adder run, generating the select
// stream and counting ones on the adder output.
module sc_adder_ctrl
    import sc_pkg::*;
#(
    parameter int          LEN_W     = 8,
    parameter int          SEL_MODE  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             adder_out,
    output logic             sel,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count
);

    // an all-zero seed would lock the LFSR
    localparam logic [SC_LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

    sc_state_e        state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             toggle_q, toggle_d;
    logic             lfsr_load, lfsr_step;
    logic [SC_LFSR_W-1:0] lfsr_q;
    logic             lfsr_msb;
    logic [SC_LFSR_W-2:0] lfsr_unused;

    sc_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (SEED),
        .q    (lfsr_q)
    );

    assign {lfsr_msb, lfsr_unused} = lfsr_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        toggle_d    = toggle_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        case (state_q)
            SC_IDLE: begin
                if (start) begin
                    count_d     = '0;
                    remaining_d = len;
                    toggle_d    = 1'b0;
                    lfsr_load   = 1'b1;
                    state_d     = (len != '0) ? SC_RUN : SC_DONE;
                end
            end
            SC_RUN: begin
                if (abort) begin
                    state_d = SC_IDLE;
                end else begin
                    count_d     = count_q + LEN_W'(adder_out);
                    remaining_d = remaining_q - LEN_W'(1);
                    lfsr_step   = 1'b1;
                    toggle_d    = ~toggle_q;
                    state_d     = (remaining_q == LEN_W'(1)) ? SC_DONE : SC_RUN;
                end
            end
            SC_DONE: state_d = SC_IDLE;
            default: state_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SC_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            toggle_q    <= toggle_d;
        end
    end

    // abort gates en combinationally so the aborted cycle consumes no bits
    assign en    = (state_q == SC_RUN) && !abort;
    assign sel   = (state_q == SC_RUN) && ((SEL_MODE == SC_SEL_TOGGLE) ? toggle_q : lfsr_msb);
    assign busy  = (state_q != SC_IDLE);
    assign done  = (state_q == SC_DONE);
    assign count = count_q;

endmodule

// File: tb/tb_sc_adder_ctrl.sv
// tb_sc_adder_ctrl: scoreboard bench driving an LFSR-mode and a toggle-mode
// controller side by side with shared stimulus.
module tb_sc_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] len = '0;
    logic       x = 1'b0;
    logic       y = 1'b0;
    logic       sel0, en0, busy0, done0;
    logic       sel1, en1, busy1, done1;
    logic [7:0] count0, count1;
    logic       adder0, adder1;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic en;
        logic busy;
        logic done;
        logic sel0;
        logic sel1;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // sc_adder: sel=0 passes x, sel=1 passes y
    assign adder0 = sel0 ? y : x;
    assign adder1 = sel1 ? y : x;

    sc_adder_ctrl #(.LEN_W(8), .SEL_MODE(0), .LFSR_SEED(16'hACE1)) u_lfsr_mode (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .adder_out(adder0), .sel(sel0), .en(en0), .busy(busy0), .done(done0), .count(count0)
    );

    sc_adder_ctrl #(.LEN_W(8), .SEL_MODE(1), .LFSR_SEED(16'hACE1)) u_toggle_mode (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .adder_out(adder1), .sel(sel1), .en(en1), .busy(busy1), .done(done1), .count(count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rs_at/ab_at/rst_at: run cycle (1 = first en cycle) for restart, abort, reset; 0 = none
    task automatic run(input int l, input logic xv, input logic yv,
                       input int rs_at, input int ab_at, input int rst_at);
        logic [15:0] ml;
        logic        mt;
        int          c0, c1, last;
        exp_t        e;
        ml = 16'hACE1;
        mt = 1'b0;
        c0 = 0;
        c1 = 0;
        last = (rst_at > 0) ? rst_at : (ab_at > 0) ? ab_at : l + 1;
        for (int c = 1; c <= last; c++) begin
            e = '0;
            if (c == rst_at) begin
                c0 = 0;
                c1 = 0;
            end else if (c == ab_at) begin
                e.busy = 1'b1;
                e.sel0 = ml[15];
                e.sel1 = mt;
            end else if (c <= l) begin
                e.en   = 1'b1;
                e.busy = 1'b1;
                e.sel0 = ml[15];
                e.sel1 = mt;
                c0 += int'(ml[15] ? yv : xv);
                c1 += int'(mt ? yv : xv);
                ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
                mt = ~mt;
            end else begin
                e.busy = 1'b1;
                e.done = 1'b1;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        x = xv;
        y = yv;
        start = 1'b1;
        len = 8'(l);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            start = (c == rs_at);
            abort = (c == ab_at);
            rst   = (c == rst_at);
            @(negedge clk);
            e = sb.pop_front();
            chk("en0", en0, e.en);
            chk("en1", en1, e.en);
            chk("sel0", sel0, e.sel0);
            chk("sel1", sel1, e.sel1);
            chk("busy", busy0, e.busy);
            chk("done0", done0, e.done);
            chk("done1", done1, e.done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle_busy0", busy0, 1'b0);
        chk("idle_busy1", busy1, 1'b0);
        chk("idle_en", en0, 1'b0);
        chk("count0", 32'(count0), 32'(c0));
        chk("count1", 32'(count1), 32'(c1));
    endtask

    initial begin
        @(negedge clk);
        chk("rst_sel", sel0, 1'b0);
        chk("rst_en", en0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_count", 32'(count0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(10, 1'b1, 1'b0, 0, 0, 0);
        run(200, 1'b1, 1'b1, 0, 0, 0);
        run(200, 1'b0, 1'b0, 0, 0, 0);
        run(255, 1'b1, 1'b0, 0, 0, 0);
        run(255, 1'b1, 1'b0, 0, 0, 0);
        run(0, 1'b1, 1'b1, 0, 0, 0);
        run(20, 1'b1, 1'b0, 5, 12, 0);
        run(50, 1'b1, 1'b1, 0, 0, 30);
        run(4, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run(int'($urandom_range(1, 40)), 1'($urandom), 1'($urandom), 0, 0, 0);
        run(1, 1'b0, 1'b1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sc_adder_ctrl.md
Name: sc_adder_ctrl

Overview:
Sequencer for one stochastic adder (sc_adder) evaluation.
- On a start command it runs the adder for a programmed number of bit-cycles.
- Generates the adder's 0.5-probability select stream from an internal 16-bit LFSR, or from a toggle flip-flop in exact-half mode.
- Strobes the x/y stream sources with an enable and counts 1s on the adder output.
- Returns the count with a done pulse.
- Sits between the host/config logic and the adder plus its bitstream generators.

Parameters:
- LEN_W, 8: width of the stream-length input and of the ones count.
- SEL_MODE, 0: 0 = LFSR select stream; 1 = toggle select stream (0,1,0,1,...).
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset and at every accepted start; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- len  in  LEN_W  stream length in bit-cycles; latched when start is accepted.
- abort  in  1  terminates a run early.
- adder_out  in  1  sc_adder output for the current cycle (combinational from sel, x, y).
- sel  out  1  select to sc_adder.
- en  out  1  advance strobe to the x/y stream generators; 1 = the current bit is consumed.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- count  out  LEN_W  number of cycles with en=1 and adder_out=1 in the last run.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, immediate): state=IDLE, sel=0, en=0, busy=0, done=0, count=0, remaining=0, toggle=0, lfsr=LFSR_SEED.
- IDLE, start=1, len!=0:
  - latch remaining=len, clear count, load lfsr=LFSR_SEED, clear toggle.
  - next state RUN.
- IDLE, start=1, len=0: count=0; next state DONE (no en cycles).
- IDLE, start=0: hold all state; count keeps its last value.
- RUN, every cycle:
  - en=1; sel = lfsr[15] (SEL_MODE=0) or toggle (SEL_MODE=1).
  - count += adder_out, sampled in the same cycle; the adder is combinational.
  - remaining -= 1; lfsr steps; toggle inverts.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Steps only in RUN; never reaches zero.
- RUN exit: the cycle with remaining==1 is the last en cycle; next state DONE. en is high for exactly len consecutive cycles, starting the cycle after start is sampled.
- RUN, abort=1:
  - that cycle is not counted; en=0 in that cycle (combinational gate).
  - next state IDLE; no done pulse; count holds the partial value.
- DONE: done=1 and en=0 for exactly one cycle; next state IDLE. Latency start→done = len+1 cycles (1 cycle for len=0).
- sel and en are driven only from registers or state decode, except for the abort gate on en.
- sel is 0 outside RUN.
- start while busy: ignored, no queuing.
- start and abort together in IDLE: start wins.
- Overflow: count cannot overflow, since len ≤ 2^LEN_W−1.
- Reset asserted mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Shared package sc_pkg holds:
  - state encoding (SC_IDLE=2'd0, SC_RUN=2'd1, SC_DONE=2'd2);
  - SC_LFSR_W=16 and the tap constant 16'hB400;
  - SC_SEL_LFSR/SC_SEL_TOGGLE.
- One natural sub-module: sc_lfsr16 (clk, rst, load, step, seed, q). The team reuses it for other stochastic number generators.

Test Plan:
- SEL_MODE=1, x=1, y=0, len=10, start → sel=0,1,0,1,... over 10 en cycles; done on cycle 11; count=5.
- SEL_MODE=0, x=y=1, len=200 → count=200. With x=y=0 → count=0. First sel=1 (MSB of 16'hACE1). Sel sequence matches the bench LFSR model bit-for-bit.
- SEL_MODE=0, x=1, y=0, len=255 → count equals the number of zeros in the model's first 255 sel bits. A second identical run gives the identical count (reseed at start).
- len=0, start → done one cycle later; no en pulses; count=0.
- len=20; start re-pulsed at cycle 5; abort at cycle 12 → second start ignored; en high for 11 cycles; no done; busy falls; count = partial value.
- len=50; assert rst at run cycle 30 → all outputs 0 immediately. A new start with len=4 then completes normally with done after 5 cycles.
